// File: rtl/sram_boot_loader_if.sv
// Word-stream handshake carrying the boot image into the loader.
interface sram_boot_loader_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/sram_boot_loader.sv
// Boot loader: receives length/data/checksum words, writes data to SRAM from
// address 0, then hands the SRAM port to the CPU and releases its reset.
module sram_boot_loader #(
    parameter int unsigned N              = 8,
    parameter int unsigned RF_addressBits = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    sram_boot_loader_if.slave           stream,
    output logic                        cpu_rst_n,
    output logic                        load_done,
    output logic                        load_error,
    input  logic                        cpu_SRAM_readEnable,
    input  logic                        cpu_SRAM_writeEnable,
    input  logic [(2**RF_addressBits)-1:0] cpu_SRAM_address,
    input  logic [N-1:0]                cpu_SRAM_data_in,
    output logic                        SRAM_readEnable,
    output logic                        SRAM_writeEnable,
    output logic [(2**RF_addressBits)-1:0] SRAM_address,
    output logic [N-1:0]                SRAM_data_in
);
    localparam int unsigned A = 2 ** RF_addressBits;

    typedef enum logic [2:0] {LEN, DATA, CHECK, RUN, ERROR} state_t;

    state_t         state, stateNext;
    logic [N-1:0]   lenWord, lenNext;
    logic [N-1:0]   wordCount, countNext;
    logic [N-1:0]   runSum, sumNext;
    logic           wrEnReg, wrEnNext;
    logic [A-1:0]   addrReg, addrNext;
    logic [N-1:0]   dataReg, dataNext;
    logic           cpuRstReg, cpuRstNext;
    logic           doneReg, doneNext;
    logic           errReg, errNext;
    logic           accept;

    assign stream.in_ready = (state == LEN) || (state == DATA) || (state == CHECK);
    assign accept          = stream.in_valid && stream.in_ready;

    // State and loader registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LEN;
            lenWord   <= '0;
            wordCount <= '0;
            runSum    <= '0;
            wrEnReg   <= 1'b0;
            addrReg   <= '0;
            dataReg   <= '0;
            cpuRstReg <= 1'b0;
            doneReg   <= 1'b0;
            errReg    <= 1'b0;
        end else begin
            state     <= stateNext;
            lenWord   <= lenNext;
            wordCount <= countNext;
            runSum    <= sumNext;
            wrEnReg   <= wrEnNext;
            addrReg   <= addrNext;
            dataReg   <= dataNext;
            cpuRstReg <= cpuRstNext;
            doneReg   <= doneNext;
            errReg    <= errNext;
        end
    end

    // Next-state logic; SRAM write registers return to idle unless a word lands
    always_comb begin
        stateNext  = state;
        lenNext    = lenWord;
        countNext  = wordCount;
        sumNext    = runSum;
        wrEnNext   = 1'b0;
        addrNext   = '0;
        dataNext   = '0;
        cpuRstNext = cpuRstReg;
        doneNext   = doneReg;
        errNext    = errReg;
        unique case (state)
            LEN: if (accept) begin
                lenNext   = stream.in_data;
                countNext = '0;
                sumNext   = '0;
                stateNext = (stream.in_data == '0) ? CHECK : DATA;
            end
            DATA: if (accept) begin
                wrEnNext  = 1'b1;
                addrNext  = A'(wordCount);
                dataNext  = stream.in_data;
                sumNext   = runSum + stream.in_data;
                countNext = wordCount + N'(1);
                if ((wordCount + N'(1)) == lenWord) stateNext = CHECK;
            end
            CHECK: if (accept) begin
                if (stream.in_data == runSum) begin
                    stateNext  = RUN;
                    cpuRstNext = 1'b1;
                    doneNext   = 1'b1;
                end else begin
                    stateNext = ERROR;
                    errNext   = 1'b1;
                end
            end
            RUN, ERROR: ;
            default: stateNext = LEN;
        endcase
    end

    // The CPU owns the SRAM port combinationally once the image is accepted
    always_comb begin
        if (state == RUN) begin
            SRAM_readEnable  = cpu_SRAM_readEnable;
            SRAM_writeEnable = cpu_SRAM_writeEnable;
            SRAM_address     = cpu_SRAM_address;
            SRAM_data_in     = cpu_SRAM_data_in;
        end else begin
            SRAM_readEnable  = 1'b0;
            SRAM_writeEnable = wrEnReg;
            SRAM_address     = addrReg;
            SRAM_data_in     = dataReg;
        end
    end

    assign cpu_rst_n  = cpuRstReg;
    assign load_done  = doneReg;
    assign load_error = errReg;
endmodule

// File: tb/tb_sram_boot_loader.sv
// Directed self-checking bench for the SRAM boot loader.
module tb_sram_boot_loader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_rst_n, load_done, load_error;
    logic       cpu_re, cpu_we;
    logic [7:0] cpu_addr, cpu_data;
    logic       SRAM_readEnable, SRAM_writeEnable;
    logic [7:0] SRAM_address, SRAM_data_in;

    int errors = 0;
    int checks = 0;
    int cycleCnt = 0;

    logic [7:0] txWords[$];
    logic [7:0] logAddr[$];
    logic [7:0] logData[$];
    int         logCycle[$];

    sram_boot_loader_if #(.N(8)) sif();

    sram_boot_loader #(.N(8), .RF_addressBits(3)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .stream               (sif.slave),
        .cpu_rst_n            (cpu_rst_n),
        .load_done            (load_done),
        .load_error           (load_error),
        .cpu_SRAM_readEnable  (cpu_re),
        .cpu_SRAM_writeEnable (cpu_we),
        .cpu_SRAM_address     (cpu_addr),
        .cpu_SRAM_data_in     (cpu_data),
        .SRAM_readEnable      (SRAM_readEnable),
        .SRAM_writeEnable     (SRAM_writeEnable),
        .SRAM_address         (SRAM_address),
        .SRAM_data_in         (SRAM_data_in)
    );

    always #5 clk = ~clk;

    // Record every write the SRAM would capture at this edge
    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
        if (SRAM_writeEnable) begin
            logAddr.push_back(SRAM_address);
            logData.push_back(SRAM_data_in);
            logCycle.push_back(cycleCnt);
        end
    end

    task automatic clearLog();
        logAddr.delete();
        logData.delete();
        logCycle.delete();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 clearLog();
    endtask

    // Sends txWords with 'gap' idle cycles between words; called at #1 after an edge
    task automatic sendWords(input int gap);
        for (int i = 0; i < txWords.size(); i++) begin
            checks++;
            if (sif.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL in_ready_before_word%0d: got %b want 1", i, sif.in_ready);
            end
            sif.in_valid = 1'b1;
            sif.in_data  = txWords[i];
            @(posedge clk);
            #1;
            if (gap > 0 && i != txWords.size() - 1) begin
                sif.in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        sif.in_valid = 1'b0;
    endtask

    task automatic checkBit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic checkByte(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%02h want 0x%02h", name, got, want);
        end
    endtask

    task automatic checkInt(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checkBit("reset_in_ready", sif.in_ready, 1'b1);
        checkBit("reset_cpu_rst_n", cpu_rst_n, 1'b0);
        checkBit("reset_load_done", load_done, 1'b0);
        checkBit("reset_load_error", load_error, 1'b0);
        checkBit("reset_sram_re", SRAM_readEnable, 1'b0);
        checkBit("reset_sram_we", SRAM_writeEnable, 1'b0);
        checkByte("reset_sram_addr", SRAM_address, 8'h00);
        checkByte("reset_sram_data", SRAM_data_in, 8'h00);
        doReset();
    endtask

    task automatic test_good_load();
        doReset();
        txWords = '{8'h03, 8'h11, 8'h22, 8'h33};
        sendWords(0);
        checkBit("good_cpu_rst_before_check", cpu_rst_n, 1'b0);
        txWords = '{8'h66};
        sendWords(0);
        checkBit("good_cpu_rst_n", cpu_rst_n, 1'b1);
        checkBit("good_load_done", load_done, 1'b1);
        checkBit("good_load_error", load_error, 1'b0);
        checkBit("good_in_ready", sif.in_ready, 1'b0);
        checkInt("good_write_count", logAddr.size(), 3);
        if (logAddr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checkByte($sformatf("good_addr%0d", i), logAddr[i], 8'(i));
                checkByte($sformatf("good_data%0d", i), logData[i], 8'(8'h11 * (i + 1)));
            end
            checkInt("good_consecutive_1", logCycle[1] - logCycle[0], 1);
            checkInt("good_consecutive_2", logCycle[2] - logCycle[1], 1);
        end
    endtask

    task automatic test_passthrough();
        // Continues from RUN left by test_good_load
        cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 8'h05; cpu_data = 8'hA5;
        #1;
        checkBit("run_sram_we", SRAM_writeEnable, 1'b1);
        checkBit("run_sram_re", SRAM_readEnable, 1'b1);
        checkByte("run_sram_addr", SRAM_address, 8'h05);
        checkByte("run_sram_data", SRAM_data_in, 8'hA5);
        cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = 8'h00; cpu_data = 8'h00;
    endtask

    task automatic test_bad_checksum();
        doReset();
        txWords = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h67};
        sendWords(0);
        checkBit("bad_load_error", load_error, 1'b1);
        checkBit("bad_cpu_rst_n", cpu_rst_n, 1'b0);
        checkBit("bad_in_ready", sif.in_ready, 1'b0);
        checkBit("bad_load_done", load_done, 1'b0);
        clearLog();
        for (int i = 0; i < 3; i++) begin
            sif.in_valid = 1'b1; sif.in_data = 8'h5A;
            @(posedge clk); #1;
            sif.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        checkInt("bad_no_writes_after", logAddr.size(), 0);
        checkBit("bad_error_sticky", load_error, 1'b1);
        checkBit("bad_sram_we_idle", SRAM_writeEnable, 1'b0);
    endtask

    task automatic test_zero_length();
        doReset();
        txWords = '{8'h00, 8'h00};
        sendWords(0);
        checkInt("zero_no_writes", logAddr.size(), 0);
        checkBit("zero_load_done", load_done, 1'b1);
        checkBit("zero_cpu_rst_n", cpu_rst_n, 1'b1);
        doReset();
        txWords = '{8'h00, 8'h01};
        sendWords(0);
        checkBit("zero_bad_error", load_error, 1'b1);
        checkBit("zero_bad_done", load_done, 1'b0);
    endtask

    task automatic test_wrap_gaps();
        doReset();
        txWords = '{8'h02, 8'hFF, 8'h02, 8'h01};
        sendWords(2);
        checkBit("wrap_load_done", load_done, 1'b1);
        checkBit("wrap_load_error", load_error, 1'b0);
        checkInt("wrap_write_count", logAddr.size(), 2);
        if (logAddr.size() == 2) begin
            checkByte("wrap_addr0", logAddr[0], 8'h00);
            checkByte("wrap_data0", logData[0], 8'hFF);
            checkByte("wrap_addr1", logAddr[1], 8'h01);
            checkByte("wrap_data1", logData[1], 8'h02);
            checkInt("wrap_gap_spacing", logCycle[1] - logCycle[0], 3);
        end
    endtask

    task automatic test_cpu_before_run();
        doReset();
        cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 8'h05; cpu_data = 8'hA5;
        #1;
        checkBit("pre_sram_we", SRAM_writeEnable, 1'b0);
        checkBit("pre_sram_re", SRAM_readEnable, 1'b0);
        checkByte("pre_sram_addr", SRAM_address, 8'h00);
        checkByte("pre_sram_data", SRAM_data_in, 8'h00);
        cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = 8'h00; cpu_data = 8'h00;
    endtask

    task automatic test_midload_reset();
        doReset();
        txWords = '{8'h04, 8'hAA, 8'hBB};
        sendWords(0);
        checkBit("mid_we_before_reset", SRAM_writeEnable, 1'b1);
        rst_n = 1'b0;
        #1;
        checkBit("mid_in_ready", sif.in_ready, 1'b1);
        checkBit("mid_sram_we", SRAM_writeEnable, 1'b0);
        checkByte("mid_sram_addr", SRAM_address, 8'h00);
        checkByte("mid_sram_data", SRAM_data_in, 8'h00);
        checkBit("mid_cpu_rst_n", cpu_rst_n, 1'b0);
        doReset();
        txWords = '{8'h01, 8'h5C, 8'h5C};
        sendWords(0);
        checkInt("reload_write_count", logAddr.size(), 1);
        if (logAddr.size() == 1) begin
            checkByte("reload_addr", logAddr[0], 8'h00);
            checkByte("reload_data", logData[0], 8'h5C);
        end
        checkBit("reload_done", load_done, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_data  = 8'h00;
        cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = 8'h00; cpu_data = 8'h00;
        test_reset();
        test_good_load();
        test_passthrough();
        test_bad_checksum();
        test_zero_length();
        test_wrap_gaps();
        test_cpu_before_run();
        test_midload_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
